// File: rtl/io_load_controller_if.sv
// Host/memory link bundle of the load controller: command lines, word stream
// with its done pacing, byte-write port and the convolution start pulse.
interface io_load_controller_if #(
    parameter int ADDR_W = 16
) ();
    logic              interrupt;
    logic              load;
    logic              cnn;
    logic [15:0]       data;
    logic              done;
    logic              mem_we;
    logic              mem_sel;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              proc_start;

    modport master (
        output interrupt, load, cnn, data,
        input  done, mem_we, mem_sel, mem_addr, mem_wdata, proc_start
    );

    modport slave (
        input  interrupt, load, cnn, data,
        output done, mem_we, mem_sel, mem_addr, mem_wdata, proc_start
    );
endinterface

// File: rtl/io_load_controller.sv
// Receive-side load controller: decodes host commands, paces the word stream
// with done, and run-length expands each word into byte writes.
module io_load_controller #(
    parameter int CNN_DEPTH = 4096,
    parameter int IMG_DEPTH = 16384,
    parameter int ADDR_W    = 16
) (
    input  logic                clk,
    input  logic                rst,
    io_load_controller_if.slave bus,
    output logic                busy,
    output logic [ADDR_W:0]     cnn_len,
    output logic [ADDR_W:0]     img_len,
    output logic                overflow
);
    typedef enum logic [1:0] {IDLE, REQ, CAP, EXPAND} state_e;

    localparam logic [ADDR_W:0] CNN_LIM = (ADDR_W+1)'(CNN_DEPTH);
    localparam logic [ADDR_W:0] IMG_LIM = (ADDR_W+1)'(IMG_DEPTH);
    localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [7:0]        val_q, val_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [ADDR_W:0]   cnn_len_q, cnn_len_d;
    logic [ADDR_W:0]   img_len_q, img_len_d;
    logic [ADDR_W:0]   lim;
    logic              sel_q, sel_d;
    logic              ovf_q, ovf_d;
    logic              we_q, we_d;
    logic              done_q, done_d;
    logic              proc_q, proc_d;
    logic              busy_q, busy_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [7:0]        wdata_q, wdata_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        val_d     = val_q;
        addr_d    = addr_q;
        sel_d     = sel_q;
        cnn_len_d = cnn_len_q;
        img_len_d = img_len_q;
        ovf_d     = ovf_q;
        proc_d    = 1'b0;

        // The write on the bus this cycle completes at this edge, even if a
        // command is also arriving; it stays counted.
        if (we_q) begin
            addr_d = addr_q + ONE;
            if (sel_q) cnn_len_d = cnn_len_q + ONE;
            else       img_len_d = img_len_q + ONE;
        end

        unique case (state_q)
            IDLE: ;
            REQ:  state_d = CAP;
            CAP: begin
                cnt_d   = bus.data[15:8];
                val_d   = bus.data[7:0];
                state_d = (bus.data[15:8] == 8'd0) ? REQ : EXPAND;
            end
            EXPAND: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) state_d = REQ;
            end
            default: state_d = IDLE;
        endcase

        // Commands pre-empt whatever the FSM was doing, including a partial run.
        if (bus.interrupt) begin
            if (bus.load) begin
                sel_d   = bus.cnn;
                addr_d  = '0;
                ovf_d   = 1'b0;
                state_d = REQ;
                if (bus.cnn) cnn_len_d = '0;
                else         img_len_d = '0;
            end else begin
                proc_d  = 1'b1;
                state_d = IDLE;
            end
        end

        // Counter freezes at the limit; expansion keeps its pace but writes nothing.
        lim  = sel_d ? CNN_LIM : IMG_LIM;
        we_d = (state_d == EXPAND) && (addr_d != lim);
        if ((state_d == EXPAND) && (addr_d == lim)) ovf_d = 1'b1;

        done_d     = (state_d == REQ);
        busy_d     = (state_d != IDLE);
        mem_addr_d = addr_d[ADDR_W-1:0];
        wdata_d    = val_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            val_q      <= '0;
            addr_q     <= '0;
            sel_q      <= 1'b0;
            cnn_len_q  <= '0;
            img_len_q  <= '0;
            ovf_q      <= 1'b0;
            we_q       <= 1'b0;
            done_q     <= 1'b0;
            proc_q     <= 1'b0;
            busy_q     <= 1'b0;
            mem_addr_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            val_q      <= val_d;
            addr_q     <= addr_d;
            sel_q      <= sel_d;
            cnn_len_q  <= cnn_len_d;
            img_len_q  <= img_len_d;
            ovf_q      <= ovf_d;
            we_q       <= we_d;
            done_q     <= done_d;
            proc_q     <= proc_d;
            busy_q     <= busy_d;
            mem_addr_q <= mem_addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.done       = done_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_sel    = sel_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = wdata_q;
    assign bus.proc_start = proc_q;
    assign busy           = busy_q;
    assign cnn_len        = cnn_len_q;
    assign img_len        = img_len_q;
    assign overflow       = ovf_q;
endmodule
